// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-ported data memory between the CPU (port 0)
// and the host loader (port 1); one transaction in flight, fixed read latency.
module dmem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_served;
  logic          winner;
  logic          granted;
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          misaligned;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [CW-1:0] cnt;

  // Grant is combinational; reset suppresses it so a request seen with rst is ignored.
  always_comb begin
    granted  = 1'b0;
    grant_id = 1'b0;
    if (state == IDLE && !rst) begin
      if (p0_req_valid && p1_req_valid) begin
        granted  = 1'b1;
        grant_id = ~last_served;
      end else if (p0_req_valid) begin
        granted  = 1'b1;
        grant_id = 1'b0;
      end else if (p1_req_valid) begin
        granted  = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign p0_req_ready = granted && !grant_id;
  assign p1_req_ready = granted && grant_id;
  assign sel_we       = grant_id ? p1_we    : p0_we;
  assign sel_addr     = grant_id ? p1_addr  : p0_addr;
  assign sel_wdata    = grant_id ? p1_wdata : p0_wdata;
  assign misaligned   = (sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (granted) state_nxt = misaligned ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= 1'b1;
      winner      <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (granted) begin
          winner      <= grant_id;
          last_served <= grant_id;
          lat_we      <= sel_we;
          lat_addr    <= sel_addr;
          lat_wdata   <= sel_wdata;
          rsp_data    <= '0;
          rsp_err     <= misaligned;
        end
        ISSUE: cnt <= CW'(LAT - 1);
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) rsp_data <= lat_we ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Memory bus and response ports are forced to zero outside their strobes.
  assign mem_en       = (state == ISSUE);
  assign mem_we       = mem_en && lat_we;
  assign mem_addr     = mem_en ? lat_addr  : '0;
  assign mem_wdata    = mem_en ? lat_wdata : '0;
  assign p0_rsp_valid = (state == RESP) && !winner;
  assign p1_rsp_valid = (state == RESP) && winner;
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;
  assign p0_rsp_err   = p0_rsp_valid && rsp_err;
  assign p1_rsp_err   = p1_rsp_valid && rsp_err;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a LAT=1 instance with a behavioural memory
// and a LAT=3 instance whose mem_rdata is driven cycle by cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        a3_valid, a3_ready, a3_rsp_valid, a3_rsp_err, a3_p1_ready, a3_p1_rsp_valid, a3_p1_rsp_err;
  logic [31:0] a3_addr, a3_rsp_rdata, a3_p1_rsp_rdata;
  logic        a3_mem_en, a3_mem_we, a3_busy;
  logic [31:0] a3_mem_addr, a3_mem_wdata, a3_mem_rdata;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int men_cnt  = 0;
  int p0_pulses = 0;
  int viol     = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.AW(32), .DW(32), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.AW(32), .DW(32), .LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .p0_req_valid(a3_valid), .p0_req_ready(a3_ready), .p0_we(1'b0),
    .p0_addr(a3_addr), .p0_wdata(32'h0), .p0_rsp_valid(a3_rsp_valid),
    .p0_rsp_rdata(a3_rsp_rdata), .p0_rsp_err(a3_rsp_err),
    .p1_req_valid(1'b0), .p1_req_ready(a3_p1_ready), .p1_we(1'b0),
    .p1_addr(32'h0), .p1_wdata(32'h0), .p1_rsp_valid(a3_p1_rsp_valid),
    .p1_rsp_rdata(a3_p1_rsp_rdata), .p1_rsp_err(a3_p1_rsp_err),
    .mem_en(a3_mem_en), .mem_we(a3_mem_we), .mem_addr(a3_mem_addr), .mem_wdata(a3_mem_wdata),
    .mem_rdata(a3_mem_rdata), .busy(a3_busy)
  );

  // Behavioural memory for the LAT=1 instance; non-read cycles return junk.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rd_q;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_idx] <= pl_val;
    else if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    rd_q <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : 32'hBAD0_BAD0;
  end
  assign mem_rdata = rd_q;

  // Response monitor feeding the observed queue, plus gating invariants.
  always @(negedge clk) begin
    rsp_t o;
    if (p0_rsp_valid === 1'b1) begin
      o.port = 1'b0; o.rdata = p0_rsp_rdata; o.err = p0_rsp_err; o.cyc = cyc;
      obs_q.push_back(o);
      p0_pulses++;
    end
    if (p1_rsp_valid === 1'b1) begin
      o.port = 1'b1; o.rdata = p1_rsp_rdata; o.err = p1_rsp_err; o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (mem_en === 1'b1) men_cnt++;
    if (p0_rsp_valid && p1_rsp_valid) viol++;
    if (p0_req_ready && p1_req_ready) viol++;
    if (!p0_rsp_valid && (p0_rsp_rdata !== 32'h0 || p0_rsp_err !== 1'b0)) viol++;
    if (!p1_rsp_valid && (p1_rsp_rdata !== 32'h0 || p1_rsp_err !== 1'b0)) viol++;
    if (!mem_en && (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)) viol++;
  end

  task automatic drive_req(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int t_acc, output bit ok);
    ok = 1'b0;
    t_acc = -1;
    @(negedge clk);
    if (port) begin p1_req_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    for (int k = 0; k < 40; k++) begin
      #1;
      if ((port ? p1_req_ready : p0_req_ready) === 1'b1) begin
        ok = 1'b1;
        t_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (port) p1_req_valid = 1'b0;
    else      p0_req_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 40; k++) begin
      if (obs_q.size() >= n) break;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    p0_req_valid = 1'b1; p0_addr = 32'h10; p1_req_valid = 1'b1; p1_addr = 32'h24;
    #1;
    total++; if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0)
      $display("FAIL reset_ready got %b%b exp 00", p0_req_ready, p1_req_ready); else pass_cnt++;
    total++; if (busy !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL reset_busy_mem got busy=%b mem_en=%b exp 0 0", busy, mem_en); else pass_cnt++;
    total++; if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0)
      $display("FAIL reset_rsp got %b%b exp 00", p0_rsp_valid, p1_rsp_valid); else pass_cnt++;
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_release_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_single_load();
    int t;
    rsp_t e, o;
    @(negedge clk);
    p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    #1;
    t = cyc;
    total++; if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL load_ready got r0=%b r1=%b busy=%b exp 1 0 0", p0_req_ready, p1_req_ready, busy); else pass_cnt++;
    e.port = 1'b0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; e.cyc = t + 3;
    exp_q.push_back(e);
    @(posedge clk); #1; p0_req_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || busy !== 1'b1)
      $display("FAIL load_issue got en=%b we=%b addr=%h busy=%b exp 1 0 10 1", mem_en, mem_we, mem_addr, busy); else pass_cnt++;
    @(negedge clk); #1;
    total++; if (mem_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL load_wait got en=%b busy=%b exp 0 1", mem_en, busy); else pass_cnt++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL load_resp_busy got %b exp 1", busy); else pass_cnt++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || p0_rsp_valid !== 1'b0)
      $display("FAIL load_done got busy=%b rsp=%b exp 0 0", busy, p0_rsp_valid); else pass_cnt++;
    total++; if (obs_q.size() != exp_q.size())
      $display("FAIL load_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL load_sb got p=%0d d=%h e=%b c=%0d exp p=%0d d=%h e=%b c=%0d",
        o.port, o.rdata, o.err, o.cyc, e.port, e.rdata, e.err, e.cyc); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_store_load_p1();
    int t, p0_before;
    bit ok;
    rsp_t e, o;
    p0_before = p0_pulses;
    drive_req(1'b1, 1'b1, 32'h20, 32'hA5A5_0001, t, ok);
    total++; if (!ok) $display("FAIL store_accept got no ready exp ready"); else pass_cnt++;
    e.port = 1'b1; e.rdata = 32'h0; e.err = 1'b0; e.cyc = t + 3;
    exp_q.push_back(e);
    wait_obs(1);
    drive_req(1'b1, 1'b0, 32'h20, 32'h0, t, ok);
    total++; if (!ok) $display("FAIL reload_accept got no ready exp ready"); else pass_cnt++;
    e.port = 1'b1; e.rdata = 32'hA5A5_0001; e.err = 1'b0; e.cyc = t + 3;
    exp_q.push_back(e);
    wait_obs(2);
    total++; if (obs_q.size() != exp_q.size())
      $display("FAIL p1_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL p1_sb got p=%0d d=%h e=%b c=%0d exp p=%0d d=%h e=%b c=%0d",
        o.port, o.rdata, o.err, o.cyc, e.port, e.rdata, e.err, e.cyc); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
    total++; if (p0_pulses != p0_before)
      $display("FAIL p1_no_p0_rsp got %0d pulses exp %0d", p0_pulses, p0_before); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    int t, m0;
    bit ok;
    rsp_t e, o;
    m0 = men_cnt;
    drive_req(1'b0, 1'b0, 32'h13, 32'h0, t, ok);
    total++; if (!ok) $display("FAIL misalign_accept got no ready exp ready"); else pass_cnt++;
    e.port = 1'b0; e.rdata = 32'h0; e.err = 1'b1; e.cyc = t + 1;
    exp_q.push_back(e);
    wait_obs(1);
    total++; if (obs_q.size() != exp_q.size())
      $display("FAIL misalign_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL misalign_sb got p=%0d d=%h e=%b c=%0d exp p=%0d d=%h e=%b c=%0d",
        o.port, o.rdata, o.err, o.cyc, e.port, e.rdata, e.err, e.cyc); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
    total++; if (men_cnt != m0) $display("FAIL misalign_no_mem got %0d mem_en exp %0d", men_cnt, m0); else pass_cnt++;
  endtask

  task automatic test_contention();
    int ng;
    int g_port [4];
    int g_cyc  [4];
    rsp_t e, o;
    ng = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    p1_req_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h24;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      #1;
      if (p0_req_ready === 1'b1 || p1_req_ready === 1'b1) begin
        g_port[ng] = (p1_req_ready === 1'b1) ? 1 : 0;
        g_cyc[ng]  = cyc;
        e.port  = (ng % 2 == 1);
        e.rdata = (ng % 2 == 1) ? 32'h2424_2424 : 32'hDEAD_BEEF;
        e.err   = 1'b0;
        e.cyc   = cyc + 3;
        exp_q.push_back(e);
        ng++;
      end
      @(negedge clk);
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    total++; if (ng != 4) $display("FAIL cont_grants got %0d exp 4", ng); else pass_cnt++;
    for (int i = 0; i < ng; i++) begin
      total++; if (g_port[i] != i % 2)
        $display("FAIL cont_order grant %0d got port %0d exp %0d", i, g_port[i], i % 2); else pass_cnt++;
      if (i > 0) begin
        total++; if (g_cyc[i] - g_cyc[i-1] != 4)
          $display("FAIL cont_spacing grant %0d got %0d exp 4", i, g_cyc[i] - g_cyc[i-1]); else pass_cnt++;
      end
    end
    wait_obs(4);
    total++; if (obs_q.size() != exp_q.size())
      $display("FAIL cont_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL cont_sb got p=%0d d=%h e=%b c=%0d exp p=%0d d=%h e=%b c=%0d",
        o.port, o.rdata, o.err, o.cyc, e.port, e.rdata, e.err, e.cyc); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    rsp_t e, o;
    @(negedge clk);
    p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    #1;
    total++; if (p0_req_ready !== 1'b1) $display("FAIL abort_accept got %b exp 1", p0_req_ready); else pass_cnt++;
    @(posedge clk); #1; p0_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h24;
    #1;
    total++; if (busy !== 1'b1) $display("FAIL abort_in_wait got busy=%b exp 1", busy); else pass_cnt++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || p0_rsp_valid !== 1'b0 || mem_en !== 1'b0 || p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0)
      $display("FAIL abort_state got busy=%b rsp=%b en=%b r=%b%b exp 0 0 0 00",
        busy, p0_rsp_valid, mem_en, p0_req_ready, p1_req_ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++; if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0)
      $display("FAIL abort_rr_reset got r=%b%b exp 10", p0_req_ready, p1_req_ready); else pass_cnt++;
    e.port = 1'b0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; e.cyc = cyc + 3;
    exp_q.push_back(e);
    @(posedge clk); #1; p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    wait_obs(1);
    @(negedge clk); #1;
    total++; if (obs_q.size() != exp_q.size())
      $display("FAIL abort_sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL abort_sb got p=%0d d=%h e=%b c=%0d exp p=%0d d=%h e=%b c=%0d",
        o.port, o.rdata, o.err, o.cyc, e.port, e.rdata, e.err, e.cyc); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lat3();
    @(negedge clk);
    a3_valid = 1'b1; a3_addr = 32'h40; a3_mem_rdata = 32'h1111_1111;
    #1;
    total++; if (a3_ready !== 1'b1) $display("FAIL lat3_ready got %b exp 1", a3_ready); else pass_cnt++;
    @(posedge clk); #1; a3_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (a3_mem_en !== 1'b1 || a3_mem_addr !== 32'h40)
      $display("FAIL lat3_issue got en=%b addr=%h exp 1 40", a3_mem_en, a3_mem_addr); else pass_cnt++;
    @(negedge clk); #1;
    total++; if (a3_mem_en !== 1'b0) $display("FAIL lat3_single_en got %b exp 0", a3_mem_en); else pass_cnt++;
    @(negedge clk); a3_mem_rdata = 32'h2222_2222;
    @(negedge clk); a3_mem_rdata = 32'h3C3C_5A5A; #1;
    total++; if (a3_rsp_valid !== 1'b0 || a3_busy !== 1'b1)
      $display("FAIL lat3_early got rsp=%b busy=%b exp 0 1", a3_rsp_valid, a3_busy); else pass_cnt++;
    @(negedge clk); a3_mem_rdata = 32'h4444_4444; #1;
    total++; if (a3_rsp_valid !== 1'b1 || a3_rsp_rdata !== 32'h3C3C_5A5A || a3_rsp_err !== 1'b0)
      $display("FAIL lat3_rsp got v=%b d=%h e=%b exp 1 3c3c5a5a 0", a3_rsp_valid, a3_rsp_rdata, a3_rsp_err); else pass_cnt++;
    @(negedge clk); #1;
    total++; if (a3_rsp_valid !== 1'b0 || a3_busy !== 1'b0 || a3_p1_rsp_valid !== 1'b0)
      $display("FAIL lat3_done got v=%b busy=%b p1v=%b exp 0 0 0", a3_rsp_valid, a3_busy, a3_p1_rsp_valid); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    p0_req_valid = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req_valid = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    a3_valid = 1'b0; a3_addr = 32'h0; a3_mem_rdata = 32'h0;
    pl_en = 1'b1; pl_idx = 8'd4; pl_val = 32'hDEAD_BEEF;
    @(negedge clk); pl_idx = 8'd9; pl_val = 32'h2424_2424;
    @(negedge clk); pl_en = 1'b0;
    test_reset();
    test_single_load();
    test_store_load_p1();
    test_misaligned();
    test_contention();
    test_reset_mid();
    test_lat3();
    total++; if (viol != 0) $display("FAIL invariants got %0d violations exp 0", viol); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
